// File: rtl/issue_unit.sv
// issue_unit: per-cycle warp arbiter between the instruction buffer and the
// operand collector / RAU. Exit requests are arbitrated first; the remaining
// issue requests are arbitrated round-robin. Grants are combinational from the
// current requests and the registered round-robin pointers.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   Req_IB_IU           per-warp issue request
//   Grt_IU_IB           per-warp issue grant (one-hot or zero)
//   Exit_Req_IB_IU      per-warp exit request
//   Exit_Grt_IU_IB      per-warp exit grant (one-hot or zero)
//   OC_Full_OC_IU       operand collector cannot accept an instruction
//   Exit_Busy_RAU_IU    RAU/TM cannot accept an exit
//   Issue_Cnt_IU        saturating count of cycles with an issue grant
//   Stall_Cnt_IU        saturating count of cycles with candidates but no grant
//
// Optional feature: define ISSUE_GREEDY_EN to re-grant the last issued warp
// ahead of the round-robin search while it keeps requesting.
module issue_unit #(
    parameter int NUM_WARPS    = 8,
    parameter int LOGNUM_WARPS = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_WARPS-1:0] Req_IB_IU,
    output logic [NUM_WARPS-1:0] Grt_IU_IB,
    input  logic [NUM_WARPS-1:0] Exit_Req_IB_IU,
    output logic [NUM_WARPS-1:0] Exit_Grt_IU_IB,
    input  logic                 OC_Full_OC_IU,
    input  logic                 Exit_Busy_RAU_IU,
    output logic [31:0]          Issue_Cnt_IU,
    output logic [15:0]          Stall_Cnt_IU
);

    localparam int unsigned NW = NUM_WARPS;

    logic [LOGNUM_WARPS-1:0] ptr_q, ptr_d;
    logic [LOGNUM_WARPS-1:0] exit_ptr_q, exit_ptr_d;
    logic [31:0]             issue_cnt_q, issue_cnt_d;
    logic [15:0]             stall_cnt_q, stall_cnt_d;

    logic [NUM_WARPS-1:0]    exit_grt;
    logic [NUM_WARPS-1:0]    issue_grt;
    logic [NUM_WARPS-1:0]    cand;
    logic                    exit_found;
    logic                    issue_found;
    logic [LOGNUM_WARPS-1:0] exit_win;
    logic [LOGNUM_WARPS-1:0] issue_win;

`ifdef ISSUE_GREEDY_EN
    logic [LOGNUM_WARPS-1:0] last_warp_q, last_warp_d;
    logic                    last_valid_q, last_valid_d;
`endif

    // First set bit of vec at or above start, wrapping modulo NUM_WARPS.
    // Returns {found, index}.
    function automatic logic [LOGNUM_WARPS:0] rr_search(
        input logic [NUM_WARPS-1:0]    vec,
        input logic [LOGNUM_WARPS-1:0] start
    );
        logic                    found;
        logic [LOGNUM_WARPS-1:0] win;
        logic [LOGNUM_WARPS-1:0] idx;
        int unsigned             pos;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            pos = 32'(start) + 32'(i);
            if (pos >= NW) begin
                pos = pos - NW;
            end
            idx = LOGNUM_WARPS'(pos);
            if (!found && vec[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    // Pointer to the warp after w, wrapping from NUM_WARPS-1 to 0.
    function automatic logic [LOGNUM_WARPS-1:0] next_ptr(
        input logic [LOGNUM_WARPS-1:0] w
    );
        if (32'(w) == NW - 32'd1) begin
            return '0;
        end
        return w + LOGNUM_WARPS'(1);
    endfunction

    // Exit arbitration, issue arbitration, pointer and counter next-state.
    always_comb begin
        exit_grt    = '0;
        issue_grt   = '0;
        ptr_d       = ptr_q;
        exit_ptr_d  = exit_ptr_q;
        issue_cnt_d = issue_cnt_q;
        stall_cnt_d = stall_cnt_q;
`ifdef ISSUE_GREEDY_EN
        last_warp_d  = last_warp_q;
        last_valid_d = last_valid_q;
`endif

        {exit_found, exit_win} = rr_search(Exit_Req_IB_IU, exit_ptr_q);
        if (!rst && !Exit_Busy_RAU_IU && exit_found) begin
            exit_grt   = NUM_WARPS'(1) << exit_win;
            exit_ptr_d = next_ptr(exit_win);
        end

        // A warp granted an exit this cycle is not eligible for issue.
        cand = Req_IB_IU & ~exit_grt;
        {issue_found, issue_win} = rr_search(cand, ptr_q);
`ifdef ISSUE_GREEDY_EN
        if (last_valid_q && cand[last_warp_q]) begin
            issue_found = 1'b1;
            issue_win   = last_warp_q;
        end
`endif

        if (!rst && !OC_Full_OC_IU && issue_found) begin
            issue_grt = NUM_WARPS'(1) << issue_win;
            ptr_d     = next_ptr(issue_win);
            if (issue_cnt_q != 32'hFFFF_FFFF) begin
                issue_cnt_d = issue_cnt_q + 32'd1;
            end
`ifdef ISSUE_GREEDY_EN
            last_warp_d  = issue_win;
            last_valid_d = 1'b1;
`endif
        end else if (!rst && (cand != '0) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            exit_ptr_q  <= '0;
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
`ifdef ISSUE_GREEDY_EN
            last_warp_q  <= '0;
            last_valid_q <= 1'b0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            exit_ptr_q  <= exit_ptr_d;
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
`ifdef ISSUE_GREEDY_EN
            last_warp_q  <= last_warp_d;
            last_valid_q <= last_valid_d;
`endif
        end
    end

    assign Grt_IU_IB      = issue_grt;
    assign Exit_Grt_IU_IB = exit_grt;
    assign Issue_Cnt_IU   = issue_cnt_q;
    assign Stall_Cnt_IU   = stall_cnt_q;

endmodule

// File: doc/issue_unit.md
ISSUE_UNIT -- requirements
Module: issue_unit

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 8, the number of warps arbitrated.
REQ-002 SHALL have parameter LOGNUM_WARPS, default $clog2(NUM_WARPS), the width of a warp index.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port Req_IB_IU, input, NUM_WARPS bits: per-warp issue request from the instruction buffer.
REQ-006 SHALL have port Grt_IU_IB, output, NUM_WARPS bits: per-warp issue grant, one-hot or zero.
REQ-007 SHALL have port Exit_Req_IB_IU, input, NUM_WARPS bits: per-warp exit request.
REQ-008 SHALL have port Exit_Grt_IU_IB, output, NUM_WARPS bits: per-warp exit grant, one-hot or zero.
REQ-009 SHALL have port OC_Full_OC_IU, input, 1 bit: the operand collector cannot accept an instruction this cycle.
REQ-010 SHALL have port Exit_Busy_RAU_IU, input, 1 bit: the RAU/TM cannot accept an exit this cycle.
REQ-011 SHALL have port Issue_Cnt_IU, output, 32 bits: performance count of issued instructions.
REQ-012 SHALL have port Stall_Cnt_IU, output, 16 bits: performance count of stalled cycles.

Function
REQ-013 Grants SHALL be combinational from the current-cycle requests and registered state (zero-cycle latency), because the buffer drives Valid to the operand collector in the same cycle it is granted.
REQ-014 Exit arbitration SHALL search Exit_Req from Exit_Ptr upward, modulo NUM_WARPS, and grant the first requesting warp; Exit_Grt SHALL be 0 while Exit_Busy_RAU_IU=1.
REQ-015 Issue candidates SHALL be Req_IB_IU with the bit of any warp exit-granted this cycle cleared; a warp requesting both exit and issue gets exit only.
REQ-016 Issue arbitration SHALL search the candidates from Ptr upward, modulo NUM_WARPS, and grant the first one; Grt SHALL be 0 while OC_Full_OC_IU=1.
REQ-017 Exit arbitration SHALL be independent of OC_Full_OC_IU; issue arbitration SHALL be independent of Exit_Busy_RAU_IU apart from REQ-015.
REQ-018 When warp w is granted, Ptr SHALL become (w+1) mod NUM_WARPS on the next edge, wrapping from NUM_WARPS-1 to 0; with no grant, Ptr SHALL hold.
REQ-019 Exit_Ptr SHALL update by the same rule as REQ-018, using exit grants.
REQ-020 At most one bit of Grt and at most one bit of Exit_Grt SHALL be set; they SHALL never select the same warp.
REQ-021 Issue_Cnt_IU SHALL increment by 1 in every cycle with Grt!=0 and SHALL saturate at 32'hFFFFFFFF.
REQ-022 Stall_Cnt_IU SHALL increment by 1 in every cycle with candidates!=0 and Grt==0, and SHALL saturate at 16'hFFFF.
REQ-023 With all requests zero, both grants SHALL be 0 and Ptr and Exit_Ptr SHALL hold.

Reset
REQ-024 While rst=1: Grt=0, Exit_Grt=0 (forced, regardless of requests); at the next edge Ptr=0, Exit_Ptr=0, Issue_Cnt=0, Stall_Cnt=0, Last_Valid=0.
REQ-025 Reset asserted mid-operation SHALL discard all arbitration state within one edge; no grant SHALL be issued in the cycle rst is high.

Configuration
REQ-026 Macro ISSUE_GREEDY_EN, when defined, SHALL add registers Last_Warp and Last_Valid, capturing the granted warp (Last_Valid=1) on each issue grant.
REQ-027 With ISSUE_GREEDY_EN, if Last_Valid=1, Last_Warp is a candidate and OC_Full=0, that warp SHALL be granted ahead of the round-robin search; Ptr SHALL still update per REQ-018.
REQ-028 Without ISSUE_GREEDY_EN, arbitration SHALL be pure round-robin per REQ-016, and Last_Warp and Last_Valid SHALL not exist.

Verification
REQ-029 Reset, then Req=8'hFF and OC_Full=0 for 9 cycles -> Grt=01,02,04,...,80,01 (round-robin build); Issue_Cnt=9.
REQ-030 Req=8'h81, Ptr=7 -> Grt=8'h80, then Grt=8'h01 (wrap).
REQ-031 Req=8'h04 with OC_Full=1 for 3 cycles -> Grt=0, Stall_Cnt=3, Ptr unchanged; OC_Full=0 -> Grt=8'h04.
REQ-032 Req=8'h06, Exit_Req=8'h02, Exit_Busy=0 -> Exit_Grt=8'h02, Grt=8'h04; repeat with Exit_Busy=1 -> Exit_Grt=0, Grt selects a warp per Ptr.
REQ-033 ISSUE_GREEDY_EN, Req=8'h03 held -> Grt=8'h01 every cycle; drop Req[0] -> Grt=8'h02.
REQ-034 rst pulsed for 1 cycle during Req=8'hFF -> Grt=0 in that cycle; the next grant is 8'h01; counters are 0.
